dmem_responder: RTL and testbench

- Memory-mapped data-memory responder on the far side of the CPU data-bus address decoder.
- When the decoder asserts CS for the window 0x0000_0500..0x0000_08FF, this block accepts one read or write and holds it off for WAIT_STATES cycles.
- It then completes the access with a one-cycle Ready pulse.
- Backing store: 256 x 32-bit words, word-addressed relative to BASE_ADDR.

---
 rtl/dmem_responder.sv | 141 ++++++++++++++
 tb/tb_dmem_responder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// dmem_responder: wait-stated 32-bit data-memory responder behind the CPU
// bus decoder window. Optional byte-lane writes via macro DMEM_BYTE_EN.
// Revision: 1.0
// ============================================================================
module dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0500,
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Address,
  input  logic        CS,
  input  logic        RD,
  input  logic        WR,
  input  logic [31:0] WriteData,
`ifdef DMEM_BYTE_EN
  input  logic [3:0]  ByteEn,
`endif
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Busy,
  output logic        AddrErr
);

  localparam int          IDX_W       = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_LIMIT = 30'(DEPTH_WORDS);
  localparam logic [2:0]  CNT_INIT    = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [2:0]  cnt;
  logic        op_wr;
  logic        err_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] read_data;
  logic [31:0] mem [DEPTH_WORDS];

  logic [29:0]      word_off;
  logic [IDX_W-1:0] req_idx;
  logic             req_err;
  logic [3:0]       req_be;
  logic             accept;
  logic             enter_resp;
  logic             eff_wr;
  logic             eff_err;
  logic [IDX_W-1:0] eff_idx;
  logic [31:0]      eff_wdata;
  logic [3:0]       eff_be;

`ifdef DMEM_BYTE_EN
  assign req_be = ByteEn;
`else
  assign req_be = 4'hF;
`endif

  // Word offset from the window base; addresses below the base wrap to a
  // huge offset and so also land in the out-of-range error.
  assign word_off = Address[31:2] - BASE_ADDR[31:2];
  assign req_idx  = word_off[IDX_W-1:0];
  assign req_err  = (Address[1:0] != 2'b00) || (RD && WR) || (word_off >= DEPTH_LIMIT);
  assign accept   = (state == S_IDLE) && CS && (RD || WR);

  // With zero wait states the response is entered straight from IDLE, so
  // the live request is used instead of the not-yet-latched copy.
  assign eff_wr    = (state == S_IDLE) ? WR        : op_wr;
  assign eff_err   = (state == S_IDLE) ? req_err   : err_q;
  assign eff_idx   = (state == S_IDLE) ? req_idx   : idx_q;
  assign eff_wdata = (state == S_IDLE) ? WriteData : wdata_q;
  assign eff_be    = (state == S_IDLE) ? req_be    : be_q;

  assign enter_resp = (accept && (WAIT_STATES == 0)) ||
                      ((state == S_WAIT) && (cnt == 3'd0));

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (cnt == 3'd0) state_next = S_RESP;
      S_RESP: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      cnt       <= 3'd0;
      op_wr     <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= 32'd0;
      be_q      <= 4'd0;
      read_data <= 32'd0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_wr   <= WR;
        err_q   <= req_err;
        idx_q   <= req_idx;
        wdata_q <= WriteData;
        be_q    <= req_be;
        cnt     <= CNT_INIT;
      end else if ((state == S_WAIT) && (cnt != 3'd0)) begin
        cnt <= cnt - 3'd1;
      end
      if (enter_resp) begin
        if (eff_err)
          read_data <= 32'd0;
        else if (!eff_wr)
          read_data <= mem[eff_idx];
      end
    end
  end

  // Storage is deliberately not reset; a reset edge suppresses the write.
  always_ff @(posedge CLK) begin
    if (!RST && enter_resp && eff_wr && !eff_err) begin
      for (int k = 0; k < 4; k++) begin
        if (eff_be[k])
          mem[eff_idx][8*k +: 8] <= eff_wdata[8*k +: 8];
      end
    end
  end

  assign ReadData = read_data;
  assign Ready    = (state == S_RESP);
  assign Busy     = (state != S_IDLE);
  assign AddrErr  = (state == S_RESP) && err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// Directed self-checking bench for dmem_responder (default parameters).
module tb_dmem_responder;

  localparam int WS = 1;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] Address;
  logic        CS;
  logic        RD;
  logic        WR;
  logic [31:0] WriteData;
  logic [3:0]  ByteEn;
  logic [31:0] ReadData;
  logic        Ready;
  logic        Busy;
  logic        AddrErr;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  dmem_responder dut (
    .CLK       (CLK),
    .RST       (RST),
    .Address   (Address),
    .CS        (CS),
    .RD        (RD),
    .WR        (WR),
    .WriteData (WriteData),
`ifdef DMEM_BYTE_EN
    .ByteEn    (ByteEn),
`endif
    .ReadData  (ReadData),
    .Ready     (Ready),
    .Busy      (Busy),
    .AddrErr   (AddrErr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // One complete access; the request is presented for exactly the accept edge.
  task automatic access(input string tag, input logic [31:0] addr, input logic rd,
                        input logic wr, input logic [31:0] wdata, input logic [3:0] be,
                        input logic exp_err, input logic chk_rd, input logic [31:0] exp_rd);
    int n;
    CS = 1'b1; Address = addr; RD = rd; WR = wr; WriteData = wdata; ByteEn = be;
    tick;
    CS = 1'b0; RD = 1'b0; WR = 1'b0;
    check({tag, "_busy"}, 32'(Busy), 32'd1);
    n = 1;
    while (!Ready && n < 10) begin
      tick;
      n++;
    end
    check({tag, "_latency"}, n, WS + 1);
    check({tag, "_ready"}, 32'(Ready), 32'd1);
    check({tag, "_addrerr"}, 32'(AddrErr), 32'(exp_err));
    if (chk_rd) check({tag, "_rdata"}, ReadData, exp_rd);
    tick;
    check({tag, "_ready_drop"}, 32'(Ready), 32'd0);
    check({tag, "_idle"}, 32'(Busy), 32'd0);
    check({tag, "_err_drop"}, 32'(AddrErr), 32'd0);
  endtask

  initial begin
    RST = 1'b1; CS = 1'b1; WR = 1'b1; RD = 1'b0;
    Address = 32'h0000_0500; WriteData = 32'h5A5A_5A5A; ByteEn = 4'hF;

    // Reset held with a live write request
    for (int i = 0; i < 2; i++) begin
      tick;
      check("rst_ready", 32'(Ready), 32'd0);
      check("rst_busy", 32'(Busy), 32'd0);
      check("rst_addrerr", 32'(AddrErr), 32'd0);
      check("rst_rdata", ReadData, 32'd0);
    end
    RST = 1'b0; CS = 1'b0; WR = 1'b0;
    tick;
    check("post_rst_idle", 32'(Busy), 32'd0);

    // Basic write / read
    access("wr500", 32'h0000_0500, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b1, 32'd0);
    access("rd500", 32'h0000_0500, 1'b1, 1'b0, 32'd0, 4'hF, 1'b0, 1'b1, 32'hDEAD_BEEF);

    // Top word of the window; read data held across a write
    access("wr8fc", 32'h0000_08FC, 1'b0, 1'b1, 32'hCAFE_0001, 4'hF, 1'b0, 1'b1, 32'hDEAD_BEEF);
    access("rd8fc", 32'h0000_08FC, 1'b1, 1'b0, 32'd0, 4'hF, 1'b0, 1'b1, 32'hCAFE_0001);

    // Outside-window addresses with CS low never accept
    RD = 1'b1; WR = 1'b0;
    Address = 32'h0000_04FF;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("cs0_4ff_ready", 32'(Ready), 32'd0);
      check("cs0_4ff_busy", 32'(Busy), 32'd0);
    end
    Address = 32'h0000_0900; WR = 1'b1; RD = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("cs0_900_ready", 32'(Ready), 32'd0);
      check("cs0_900_busy", 32'(Busy), 32'd0);
    end
    RD = 1'b0; WR = 1'b0;

    // Error responses
    access("err_misalign", 32'h0000_0502, 1'b0, 1'b1, 32'h1234_5678, 4'hF, 1'b1, 1'b1, 32'd0);
    access("err_rdwr", 32'h0000_0504, 1'b1, 1'b1, 32'd0, 4'hF, 1'b1, 1'b1, 32'd0);
    access("rd500_after_err", 32'h0000_0500, 1'b1, 1'b0, 32'd0, 4'hF, 1'b0, 1'b1, 32'hDEAD_BEEF);

    // Second request held through Busy is ignored
    CS = 1'b1; RD = 1'b1; Address = 32'h0000_0500;
    tick;
    Address = 32'h0000_08FC;
    check("busy_wait_ready", 32'(Ready), 32'd0);
    tick;
    check("busy_resp_ready", 32'(Ready), 32'd1);
    check("busy_resp_rdata", ReadData, 32'hDEAD_BEEF);
    CS = 1'b0; RD = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("busy_no_second_ready", 32'(Ready), 32'd0);
      check("busy_no_second_busy", 32'(Busy), 32'd0);
    end
    check("busy_rdata_held", ReadData, 32'hDEAD_BEEF);

    // Reset during WAIT aborts the write
    access("preload600", 32'h0000_0600, 1'b0, 1'b1, 32'h1111_1111, 4'hF, 1'b0, 1'b0, 32'd0);
    CS = 1'b1; WR = 1'b1; Address = 32'h0000_0600; WriteData = 32'h2222_2222;
    tick;
    CS = 1'b0; WR = 1'b0;
    check("abort_busy", 32'(Busy), 32'd1);
    RST = 1'b1;
    tick;
    check("abort_ready", 32'(Ready), 32'd0);
    check("abort_busy_clr", 32'(Busy), 32'd0);
    RST = 1'b0;
    tick;
    check("abort_no_late_ready", 32'(Ready), 32'd0);
    access("rd600", 32'h0000_0600, 1'b1, 1'b0, 32'd0, 4'hF, 1'b0, 1'b1, 32'h1111_1111);

`ifdef DMEM_BYTE_EN
    access("be_clear", 32'h0000_0504, 1'b0, 1'b1, 32'h0000_0000, 4'hF, 1'b0, 1'b0, 32'd0);
    access("be_0101", 32'h0000_0504, 1'b0, 1'b1, 32'hAABB_CCDD, 4'b0101, 1'b0, 1'b0, 32'd0);
    access("be_rd1", 32'h0000_0504, 1'b1, 1'b0, 32'd0, 4'b0000, 1'b0, 1'b1, 32'h00BB_00DD);
    access("be_none", 32'h0000_0504, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'b0000, 1'b0, 1'b0, 32'd0);
    access("be_rd2", 32'h0000_0504, 1'b1, 1'b0, 32'd0, 4'hF, 1'b0, 1'b1, 32'h00BB_00DD);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
